// File: rtl/phase_accumulator.sv
// phase_accumulator: per-operator 20-bit NCO with FM offset, registered 10-bit phase out.
// Key-on phase restart is built only when OPL2_PHASE_KEYON_RESTART_EN is defined.
module phase_accumulator #(
    parameter int NUM_OPS = 18,
    parameter int ACC_W   = 20,
    parameter int PHASE_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid_p2,
    input  logic [4:0]         op_num_p2,
    input  logic [ACC_W-1:0]   phase_inc_p2,
    input  logic               key_on_p2,
    input  logic [PHASE_W-1:0] modulation_p2,
    output logic [PHASE_W-1:0] phase_p3,
    output logic               phase_valid_p3,
    output logic [4:0]         op_num_p3
);
    localparam logic [4:0] OPS = 5'(NUM_OPS);
    logic [ACC_W-1:0] acc [NUM_OPS];
    logic             accept, restart;
    logic [4:0]       op;
    logic [ACC_W-1:0] base;
    assign accept = op_valid_p2 && (op_num_p2 < OPS);
    assign op     = accept ? op_num_p2 : 5'd0;
`ifdef OPL2_PHASE_KEYON_RESTART_EN
    logic [NUM_OPS-1:0] key_prev;
    assign restart = key_on_p2 && !key_prev[op];
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            key_prev <= '0;
        else if (accept)
            key_prev[op] <= key_on_p2;
    end
`else
    logic unused_key_on;
    assign unused_key_on = key_on_p2;
    assign restart       = 1'b0;
`endif
    assign base = restart ? '0 : acc[op];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_OPS; i++) acc[i] <= '0;
            phase_p3       <= '0;
            phase_valid_p3 <= 1'b0;
            op_num_p3      <= '0;
        end else begin
            if (accept) acc[op] <= base + phase_inc_p2;
            phase_p3       <= accept ? base[ACC_W-1 -: PHASE_W] + modulation_p2 : '0;
            phase_valid_p3 <= accept;
            op_num_p3      <= op_num_p2;
        end
    end
endmodule

// File: tb/tb_phase_accumulator.sv
// tb_phase_accumulator: directed vectors with hand-computed phases for phase_accumulator.
module tb_phase_accumulator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid_p2 = 1'b0;
    logic [4:0]  op_num_p2 = '0;
    logic [19:0] phase_inc_p2 = '0;
    logic        key_on_p2 = 1'b0;
    logic [9:0]  modulation_p2 = '0;
    logic [9:0]  phase_p3;
    logic        phase_valid_p3;
    logic [4:0]  op_num_p3;
    int checks = 0;
    int errors = 0;

    phase_accumulator dut (
        .clk(clk), .reset(reset), .op_valid_p2(op_valid_p2), .op_num_p2(op_num_p2),
        .phase_inc_p2(phase_inc_p2), .key_on_p2(key_on_p2), .modulation_p2(modulation_p2),
        .phase_p3(phase_p3), .phase_valid_p3(phase_valid_p3), .op_num_p3(op_num_p3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [9:0] ph, input logic v, input logic [4:0] opn);
        chk({tag, ".phase"}, 32'(phase_p3), 32'(ph));
        chk({tag, ".valid"}, 32'(phase_valid_p3), 32'(v));
        chk({tag, ".op"}, 32'(op_num_p3), 32'(opn));
    endtask

    task automatic drive(input logic v, input logic [4:0] opn, input logic [19:0] inc,
                         input logic k, input logic [9:0] m);
        op_valid_p2   = v;
        op_num_p2     = opn;
        phase_inc_p2  = inc;
        key_on_p2     = k;
        modulation_p2 = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 10'd0, 1'b0, 5'd0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 20'h00400, 1'b1, 10'd0);
            chk_out($sformatf("freerun%0d", i), 10'(i), 1'b1, 5'd3);
        end
        drive(1'b0, 5'd0, 20'h00000, 1'b0, 10'd0);
        chk_out("idle", 10'd0, 1'b0, 5'd0);

        drive(1'b1, 5'd0, 20'h7FE00, 1'b0, 10'd0);
        chk_out("wrap.pre0", 10'h000, 1'b1, 5'd0);
        drive(1'b1, 5'd0, 20'h7FE00, 1'b0, 10'd0);
        chk_out("wrap.pre1", 10'h1FF, 1'b1, 5'd0);
        drive(1'b1, 5'd0, 20'h00400, 1'b0, 10'd0);
        chk_out("wrap.top", 10'h3FF, 1'b1, 5'd0);
        drive(1'b1, 5'd0, 20'h00000, 1'b0, 10'd0);
        chk_out("wrap.zero", 10'h000, 1'b1, 5'd0);

        drive(1'b1, 5'd5, 20'h12345, 1'b0, 10'd0);
        chk_out("keyon.load", 10'h000, 1'b1, 5'd5);
        drive(1'b1, 5'd5, 20'h00800, 1'b1, 10'd7);
`ifdef OPL2_PHASE_KEYON_RESTART_EN
        chk_out("keyon.edge", 10'h007, 1'b1, 5'd5);
        drive(1'b1, 5'd5, 20'h00000, 1'b1, 10'd0);
        chk_out("keyon.after", 10'h002, 1'b1, 5'd5);
        drive(1'b1, 5'd5, 20'h00000, 1'b0, 10'd0);
        chk_out("keyoff.hold", 10'h002, 1'b1, 5'd5);
`else
        chk_out("keyon.edge", 10'h04F, 1'b1, 5'd5);
        drive(1'b1, 5'd5, 20'h00000, 1'b1, 10'd0);
        chk_out("keyon.after", 10'h04A, 1'b1, 5'd5);
        drive(1'b1, 5'd5, 20'h00000, 1'b0, 10'd0);
        chk_out("keyoff.hold", 10'h04A, 1'b1, 5'd5);
`endif

        drive(1'b1, 5'd7, 20'hFA000, 1'b0, 10'd0);
        chk_out("mod.load", 10'd0, 1'b1, 5'd7);
        drive(1'b1, 5'd7, 20'h00000, 1'b0, 10'd50);
        chk_out("mod.wrap", 10'd26, 1'b1, 5'd7);
        drive(1'b1, 5'd18, 20'h12345, 1'b1, 10'd5);
        chk_out("range", 10'd0, 1'b0, 5'd18);
        drive(1'b1, 5'd7, 20'h00000, 1'b0, 10'd0);
        chk_out("range.nochg", 10'd1000, 1'b1, 5'd7);

        drive(1'b1, 5'd0, 20'h01000, 1'b0, 10'd0);
        chk_out("ind.a0", 10'd0, 1'b1, 5'd0);
        drive(1'b1, 5'd17, 20'h05000, 1'b0, 10'd0);
        chk_out("ind.b0", 10'd0, 1'b1, 5'd17);
        drive(1'b1, 5'd0, 20'h02000, 1'b0, 10'd0);
        chk_out("ind.a1", 10'd4, 1'b1, 5'd0);
        drive(1'b1, 5'd0, 20'h00800, 1'b0, 10'd0);
        chk_out("ind.a2b2b", 10'd12, 1'b1, 5'd0);
        drive(1'b1, 5'd17, 20'h00400, 1'b0, 10'd0);
        chk_out("ind.b1", 10'd20, 1'b1, 5'd17);
        drive(1'b1, 5'd0, 20'h00000, 1'b0, 10'd0);
        chk_out("ind.a3", 10'd14, 1'b1, 5'd0);
        drive(1'b1, 5'd17, 20'h00000, 1'b0, 10'd0);
        chk_out("ind.b2", 10'd21, 1'b1, 5'd17);

        drive(1'b1, 5'd3, 20'h00400, 1'b1, 10'd0);
        chk_out("sweep", 10'd4, 1'b1, 5'd3);
        #3 reset = 1'b1;
        #1;
        chk_out("async_rst", 10'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(1'b1, 5'd3, 20'h00400, 1'b1, 10'd9);
        chk_out("post_rst", 10'd9, 1'b1, 5'd3);
        drive(1'b1, 5'd3, 20'h00000, 1'b1, 10'd0);
        chk_out("post_rst2", 10'd1, 1'b1, 5'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
